// File: rtl/bus_arbiter_2to1.sv
// Two-master (m0 data, m1 instruction) to one-slave memory bus arbiter with an ID FIFO for response routing.
// Latency: zero added cycles on request (comb gnt) and response (comb rvalid) paths.
// Backpressure: s_gnt stalls hold the selection locked; s_req drops while MAX_OUTSTANDING are in flight.
// Optional feature macro: BUS_ARB_ROUND_ROBIN_EN (round-robin on contention; default is fixed priority m0 > m1).
module bus_arbiter_2to1 #(
    parameter int unsigned ADDR_WIDTH      = 32,
    parameter int unsigned DATA_WIDTH      = 32,
    parameter int unsigned MAX_OUTSTANDING = 2
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    // master 0 (data port)
    input  logic                    m0_req,
    input  logic [ADDR_WIDTH-1:0]   m0_addr,
    input  logic                    m0_we,
    input  logic [DATA_WIDTH/8-1:0] m0_be,
    input  logic [DATA_WIDTH-1:0]   m0_wdata,
    output logic                    m0_gnt,
    output logic                    m0_rvalid,
    output logic [DATA_WIDTH-1:0]   m0_rdata,
    output logic                    m0_err,
    // master 1 (instruction port)
    input  logic                    m1_req,
    input  logic [ADDR_WIDTH-1:0]   m1_addr,
    input  logic                    m1_we,
    input  logic [DATA_WIDTH/8-1:0] m1_be,
    input  logic [DATA_WIDTH-1:0]   m1_wdata,
    output logic                    m1_gnt,
    output logic                    m1_rvalid,
    output logic [DATA_WIDTH-1:0]   m1_rdata,
    output logic                    m1_err,
    // slave
    output logic                    s_req,
    output logic [ADDR_WIDTH-1:0]   s_addr,
    output logic                    s_we,
    output logic [DATA_WIDTH/8-1:0] s_be,
    output logic [DATA_WIDTH-1:0]   s_wdata,
    input  logic                    s_gnt,
    input  logic                    s_rvalid,
    input  logic [DATA_WIDTH-1:0]   s_rdata,
    input  logic                    s_err
);

    localparam int unsigned CNT_W = $clog2(MAX_OUTSTANDING + 1);
    localparam int unsigned PTR_W = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
    localparam logic [CNT_W-1:0] MAX_CNT  = CNT_W'(MAX_OUTSTANDING);
    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(MAX_OUTSTANDING - 1);

    logic                       sel;        // 0 = m0, 1 = m1
    logic                       sel_q;
    logic                       lock_q;
    logic                       tie_winner;
    logic                       sel_req;
    logic                       any_req;
    logic                       push;
    logic                       pop;
    logic                       head;
    logic [MAX_OUTSTANDING-1:0] id_mem;
    logic [PTR_W-1:0]           wr_ptr;
    logic [PTR_W-1:0]           rd_ptr;
    logic [CNT_W-1:0]           count;

`ifdef BUS_ARB_ROUND_ROBIN_EN
    logic rr_last;

    // Remember who was served last so the other master wins the next tie
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rr_last <= 1'b1;
        end else if (push) begin
            rr_last <= sel;
        end
    end

    assign tie_winner = ~rr_last;
`else
    // Data port always beats instruction port on a tie
    assign tie_winner = 1'b0;
`endif

    // Pick the master; a stalled (ungranted) request keeps its slot so the slave sees a stable address
    always_comb begin
        sel = 1'b0;
        if (lock_q) begin
            sel = sel_q;
        end else if (m0_req && m1_req) begin
            sel = tie_winner;
        end else if (m1_req) begin
            sel = 1'b1;
        end
    end

    assign sel_req = sel ? m1_req : m0_req;
    assign any_req = m0_req | m1_req;

    // Full check uses the registered count only, so a same-cycle pop does not reopen the slot early
    assign s_req  = rst_ni & sel_req & (count < MAX_CNT);
    assign push   = s_req & s_gnt;
    assign m0_gnt = push & ~sel;
    assign m1_gnt = push & sel;

    // Forward the selected master's payload; drive zeros when the bus is idle
    always_comb begin
        s_addr  = '0;
        s_we    = 1'b0;
        s_be    = '0;
        s_wdata = '0;
        if (any_req) begin
            s_addr  = sel ? m1_addr  : m0_addr;
            s_we    = sel ? m1_we    : m0_we;
            s_be    = sel ? m1_be    : m0_be;
            s_wdata = sel ? m1_wdata : m0_wdata;
        end
    end

    // Hold the selection while the slave stalls; released on grant or if the request goes away
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            lock_q <= 1'b0;
            sel_q  <= 1'b0;
        end else begin
            lock_q <= s_req & ~s_gnt;
            sel_q  <= sel;
        end
    end

    // Responses with nothing outstanding are dropped rather than corrupting the FIFO
    assign pop       = s_rvalid & (count != '0);
    assign head      = id_mem[rd_ptr];
    assign m0_rvalid = pop & ~head;
    assign m1_rvalid = pop & head;
    assign m0_rdata  = s_rdata;
    assign m1_rdata  = s_rdata;
    assign m0_err    = s_err & m0_rvalid;
    assign m1_err    = s_err & m1_rvalid;

    // ID FIFO: record the issuing master per accepted request, retire in slave response order
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            id_mem <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                id_mem[wr_ptr] <= sel;
                wr_ptr         <= (wr_ptr == PTR_LAST) ? '0 : wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= (rd_ptr == PTR_LAST) ? '0 : rd_ptr + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

`ifndef SYNTHESIS
    // Flag slaves that answer without an outstanding request; the hardware itself ignores them
    always @(posedge clk_i) begin
        if (rst_ni) begin
            assert (!(s_rvalid && (count == '0)))
                else $warning("bus_arbiter_2to1: s_rvalid with no outstanding request ignored");
        end
    end
`endif

endmodule

// File: tb/tb_bus_arbiter_2to1.sv
module tb_bus_arbiter_2to1;

    logic        clk_i = 1'b0;
    logic        rst_ni;
    logic        m0_req, m0_we, m0_gnt, m0_rvalid, m0_err;
    logic [31:0] m0_addr, m0_wdata, m0_rdata;
    logic [3:0]  m0_be;
    logic        m1_req, m1_we, m1_gnt, m1_rvalid, m1_err;
    logic [31:0] m1_addr, m1_wdata, m1_rdata;
    logic [3:0]  m1_be;
    logic        s_req, s_we, s_gnt, s_rvalid, s_err;
    logic [31:0] s_addr, s_wdata, s_rdata;
    logic [3:0]  s_be;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk_i = ~clk_i;

    bus_arbiter_2to1 #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .MAX_OUTSTANDING(2)) dut (
        .clk_i(clk_i), .rst_ni(rst_ni),
        .m0_req(m0_req), .m0_addr(m0_addr), .m0_we(m0_we), .m0_be(m0_be), .m0_wdata(m0_wdata),
        .m0_gnt(m0_gnt), .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata), .m0_err(m0_err),
        .m1_req(m1_req), .m1_addr(m1_addr), .m1_we(m1_we), .m1_be(m1_be), .m1_wdata(m1_wdata),
        .m1_gnt(m1_gnt), .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata), .m1_err(m1_err),
        .s_req(s_req), .s_addr(s_addr), .s_we(s_we), .s_be(s_be), .s_wdata(s_wdata),
        .s_gnt(s_gnt), .s_rvalid(s_rvalid), .s_rdata(s_rdata), .s_err(s_err)
    );

    // Inputs change on the falling edge; outputs are sampled 1ns later, well before the rising edge
    task automatic step();
        @(negedge clk_i);
    endtask

    task automatic idle();
        m0_req = 0; m0_addr = 0; m0_we = 0; m0_be = 0; m0_wdata = 0;
        m1_req = 0; m1_addr = 0; m1_we = 0; m1_be = 0; m1_wdata = 0;
        s_gnt = 0; s_rvalid = 0; s_rdata = 0; s_err = 0;
    endtask

    task automatic test_reset();
        idle();
        rst_ni = 0;
        m1_req = 1; m1_addr = 32'h44; s_gnt = 1; s_rvalid = 1; s_err = 1;
        step(); #1;
        n_checks++; if (s_req !== 1'b0) $display("FAIL rst_s_req: got %b exp 0", s_req); else n_pass++;
        n_checks++; if ({m0_gnt, m1_gnt} !== 2'b00) $display("FAIL rst_gnt: got %b exp 00", {m0_gnt, m1_gnt}); else n_pass++;
        n_checks++; if ({m0_rvalid, m1_rvalid, m0_err, m1_err} !== 4'b0) $display("FAIL rst_rsp: got %b exp 0000", {m0_rvalid, m1_rvalid, m0_err, m1_err}); else n_pass++;
        step(); idle(); rst_ni = 1;
        step();
    endtask

    task automatic test_single();
        m1_req = 1; m1_addr = 32'h0000_0010; m1_be = 4'hF; s_gnt = 1;
        #1;
        n_checks++; if (s_req !== 1'b1) $display("FAIL t1_s_req: got %b exp 1", s_req); else n_pass++;
        n_checks++; if (s_addr !== 32'h10) $display("FAIL t1_s_addr: got %h exp 00000010", s_addr); else n_pass++;
        n_checks++; if ({m0_gnt, m1_gnt} !== 2'b01) $display("FAIL t1_gnt: got %b exp 01", {m0_gnt, m1_gnt}); else n_pass++;
        step(); idle(); s_rvalid = 1; s_rdata = 32'hCAFE_F00D;
        #1;
        n_checks++; if ({m0_rvalid, m1_rvalid} !== 2'b01) $display("FAIL t1_rvalid: got %b exp 01", {m0_rvalid, m1_rvalid}); else n_pass++;
        n_checks++; if (m1_rdata !== 32'hCAFE_F00D) $display("FAIL t1_rdata: got %h exp cafef00d", m1_rdata); else n_pass++;
        step(); idle();
    endtask

    task automatic test_fixed_prio();
        m0_req = 1; m0_addr = 32'h100; m1_req = 1; m1_addr = 32'h200; s_gnt = 1;
        #1;
        n_checks++; if ({m0_gnt, m1_gnt} !== 2'b10) $display("FAIL t2_gnt0: got %b exp 10", {m0_gnt, m1_gnt}); else n_pass++;
        n_checks++; if (s_addr !== 32'h100) $display("FAIL t2_addr0: got %h exp 00000100", s_addr); else n_pass++;
        step(); m0_req = 0; m0_addr = 0; s_rvalid = 1; s_rdata = 32'hA0;
        #1;
        n_checks++; if ({m0_gnt, m1_gnt} !== 2'b01) $display("FAIL t2_gnt1: got %b exp 01", {m0_gnt, m1_gnt}); else n_pass++;
        n_checks++; if (s_addr !== 32'h200) $display("FAIL t2_addr1: got %h exp 00000200", s_addr); else n_pass++;
        n_checks++; if ({m0_rvalid, m1_rvalid} !== 2'b10) $display("FAIL t2_rsp0: got %b exp 10", {m0_rvalid, m1_rvalid}); else n_pass++;
        step(); m1_req = 0; s_gnt = 0; s_rdata = 32'hA1; s_err = 1;
        #1;
        n_checks++; if ({m0_rvalid, m1_rvalid} !== 2'b01) $display("FAIL t2_rsp1: got %b exp 01", {m0_rvalid, m1_rvalid}); else n_pass++;
        n_checks++; if ({m0_err, m1_err} !== 2'b01) $display("FAIL t2_err: got %b exp 01", {m0_err, m1_err}); else n_pass++;
        step(); idle();
    endtask

    task automatic test_contention();
        logic [3:0] exp_m1;
`ifdef BUS_ARB_ROUND_ROBIN_EN
        exp_m1 = 4'b1010;   // bit i = grant in cycle i: m0, m1, m0, m1
`else
        exp_m1 = 4'b0000;   // m0 wins every cycle
`endif
        m0_req = 1; m0_addr = 32'h500; m1_req = 1; m1_addr = 32'h600; s_gnt = 1;
        for (int i = 0; i < 4; i++) begin
            s_rvalid = (i > 0);
            #1;
            n_checks++; if ({m0_gnt, m1_gnt} !== {~exp_m1[i], exp_m1[i]}) $display("FAIL t3_gnt[%0d]: got %b exp %b", i, {m0_gnt, m1_gnt}, {~exp_m1[i], exp_m1[i]}); else n_pass++;
            if (i > 0) begin
                n_checks++; if (m1_rvalid !== exp_m1[i-1]) $display("FAIL t3_rsp[%0d]: got %b exp %b", i, m1_rvalid, exp_m1[i-1]); else n_pass++;
            end
            step();
        end
        idle(); s_rvalid = 1;
        #1;
        n_checks++; if (m1_rvalid !== exp_m1[3]) $display("FAIL t3_rsp[4]: got %b exp %b", m1_rvalid, exp_m1[3]); else n_pass++;
        step(); idle();
    endtask

    task automatic test_stall();
        m1_req = 1; m1_addr = 32'h300;
        for (int i = 0; i < 3; i++) begin
            #1;
            n_checks++; if (s_addr !== 32'h300 || s_req !== 1'b1 || m1_gnt !== 1'b0) $display("FAIL t4_stall[%0d]: got addr %h req %b gnt %b exp 00000300 1 0", i, s_addr, s_req, m1_gnt); else n_pass++;
            step();
        end
        m0_req = 1; m0_addr = 32'h400;
        #1;
        n_checks++; if (s_addr !== 32'h300) $display("FAIL t4_locked_addr: got %h exp 00000300", s_addr); else n_pass++;
        step(); s_gnt = 1;
        #1;
        n_checks++; if ({m0_gnt, m1_gnt} !== 2'b01 || s_addr !== 32'h300) $display("FAIL t4_first: got gnt %b addr %h exp 01 00000300", {m0_gnt, m1_gnt}, s_addr); else n_pass++;
        step(); m1_req = 0; m1_addr = 0; s_rvalid = 1;
        #1;
        n_checks++; if ({m0_gnt, m1_gnt} !== 2'b10 || s_addr !== 32'h400) $display("FAIL t4_second: got gnt %b addr %h exp 10 00000400", {m0_gnt, m1_gnt}, s_addr); else n_pass++;
        n_checks++; if ({m0_rvalid, m1_rvalid} !== 2'b01) $display("FAIL t4_rsp1: got %b exp 01", {m0_rvalid, m1_rvalid}); else n_pass++;
        step(); m0_req = 0; s_gnt = 0;
        #1;
        n_checks++; if ({m0_rvalid, m1_rvalid} !== 2'b10) $display("FAIL t4_rsp0: got %b exp 10", {m0_rvalid, m1_rvalid}); else n_pass++;
        step(); idle();
    endtask

    task automatic test_full();
        logic [5:0] exp_gnt;
        exp_gnt = 6'b010011;   // bit i: handshake expected in cycle i
        m0_req = 1; m0_addr = 32'h700; s_gnt = 1;
        for (int i = 0; i < 6; i++) begin
            s_rvalid = (i == 3);
            #1;
            n_checks++; if (m0_gnt !== exp_gnt[i] || s_req !== exp_gnt[i]) $display("FAIL t5_slot[%0d]: got gnt %b req %b exp %b", i, m0_gnt, s_req, exp_gnt[i]); else n_pass++;
            if (i == 3) begin
                n_checks++; if (m0_rvalid !== 1'b1) $display("FAIL t5_pop: got %b exp 1", m0_rvalid); else n_pass++;
            end
            step();
        end
        idle(); s_rvalid = 1;
        step(); step(); idle();
    endtask

    task automatic test_spurious_and_reset();
        s_rvalid = 1; s_err = 1;
        #1;
        n_checks++; if ({m0_rvalid, m1_rvalid, m0_err, m1_err} !== 4'b0) $display("FAIL t6_spurious: got %b exp 0000", {m0_rvalid, m1_rvalid, m0_err, m1_err}); else n_pass++;
        step(); idle();
        // count must still be 0: exactly two handshakes fit before the FIFO is full
        m1_req = 1; m1_addr = 32'h800; s_gnt = 1;
        for (int i = 0; i < 3; i++) begin
            #1;
            n_checks++; if (m1_gnt !== (i < 2)) $display("FAIL t6_count[%0d]: got %b exp %b", i, m1_gnt, (i < 2)); else n_pass++;
            step();
        end
        // reset in the middle of the burst with outstanding IDs
        s_rvalid = 1; s_err = 1; rst_ni = 0;
        #1;
        n_checks++; if ({s_req, m0_gnt, m1_gnt, m0_rvalid, m1_rvalid, m0_err, m1_err} !== 7'b0) $display("FAIL t6_rst_out: got %b exp 0000000", {s_req, m0_gnt, m1_gnt, m0_rvalid, m1_rvalid, m0_err, m1_err}); else n_pass++;
        step(); idle(); rst_ni = 1;
        step();
        m1_req = 1; m1_addr = 32'h900; s_gnt = 1;
        #1;
        n_checks++; if (m1_gnt !== 1'b1) $display("FAIL t6_post_rst: got %b exp 1", m1_gnt); else n_pass++;
        step(); idle(); s_rvalid = 1;
        #1;
        n_checks++; if ({m0_rvalid, m1_rvalid} !== 2'b01) $display("FAIL t6_post_rsp: got %b exp 01", {m0_rvalid, m1_rvalid}); else n_pass++;
        step(); idle();
    endtask

    initial begin
        test_reset();
        test_single();
        test_fixed_prio();
        test_contention();
        test_stall();
        test_full();
        test_spurious_and_reset();
        step();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
